// File: rtl/tpiu_pkg.sv
// tpiu_pkg
//   Shared constants, types and helpers for the TPIU trace port receiver.
//   - WIDTH_*        : port width codes carried on the 'width' input
//   - TPIU_FULL_SYNC : 32-bit window value of a full sync (bytes FF FF FF 7F,
//                      sent LSB first, newest bit at window bit 31)
//   - TPIU_FRAME_BYTES: default TPIU frame length in bytes
//   - rx_state_e     : receiver lock state
//   - width_bits()   : width code -> number of active port bits per sample
package tpiu_pkg;

  localparam logic [1:0] WIDTH_1B = 2'd0;
  localparam logic [1:0] WIDTH_2B = 2'd1;
  localparam logic [1:0] WIDTH_4B = 2'd2;
  localparam logic [1:0] WIDTH_8B = 2'd3;

  localparam logic [31:0] TPIU_FULL_SYNC   = 32'h7FFF_FFFF;
  localparam int          TPIU_FRAME_BYTES = 16;

  typedef enum logic {
    RX_UNLOCKED = 1'b0,
    RX_LOCKED   = 1'b1
  } rx_state_e;

  // A port built with only 4 pins cannot carry 8-bit samples, so the 8-bit
  // code falls back to 4 bits there.
  function automatic logic [3:0] width_bits(input logic [1:0] code, input int max_width);
    logic [3:0] bits;
    case (code)
      WIDTH_1B: bits = 4'd1;
      WIDTH_2B: bits = 4'd2;
      WIDTH_4B: bits = 4'd4;
      default:  bits = (max_width >= 8) ? 4'd8 : 4'd4;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/tpiu_byte_delay.sv
// tpiu_byte_delay
//   DELAY-entry byte shift line with a valid bit per entry. Bytes are held
//   back so that the leading bytes of a full sync can be removed before they
//   ever reach the output.
// Ports:
//   clk, nRst   : clock, synchronous active-low reset (all entries invalid)
//   push        : shift din into entry 0; the oldest entry falls off the end
//   flush       : invalidate every entry (wins over push)
//   din         : byte to push
//   dout        : oldest entry, i.e. the byte a push this cycle evicts
//   dout_valid  : oldest entry holds a real byte
//   valid_cnt   : number of valid entries currently held
module tpiu_byte_delay
  import tpiu_pkg::*;
#(
  parameter int DELAY = 4,
  parameter int CW    = $clog2(DELAY + 1)
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          push,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          dout_valid,
  output logic [CW-1:0] valid_cnt
);

  logic [7:0]       data_q [DELAY];
  logic [7:0]       data_d [DELAY];
  logic [DELAY-1:0] vld_q;
  logic [DELAY-1:0] vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (flush) begin
      vld_d = '0;
    end else if (push) begin
      for (int i = DELAY - 1; i > 0; i--) begin
        data_d[i] = data_q[i-1];
      end
      data_d[0] = din;
      vld_d     = {vld_q[DELAY-2:0], 1'b1};
    end
  end

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < DELAY; i++) begin
      valid_cnt = valid_cnt + CW'(vld_q[i]);
    end
  end

  assign dout       = data_q[DELAY-1];
  assign dout_valid = vld_q[DELAY-1];

  always_ff @(posedge clk) begin
    if (!nRst) begin
      vld_q <= '0;
      for (int i = 0; i < DELAY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/tpiu_frame_rx.sv
// tpiu_frame_rx
//   Trace port receiver: hunts for the TPIU full sync in raw port samples,
//   assembles aligned bytes at a runtime width of 1/2/4/8 bits, strips
//   in-stream full syncs and tracks 16-byte frame alignment.
// Ports:
//   clk, nRst  : clock, synchronous active-low reset
//   width      : port width code (0=1b, 1=2b, 2=4b, 3=8b)
//   traceDin   : port sample, bit 0 earliest in time; bits above W ignored
//   traceValid : traceDin holds a new sample this cycle
//   dOut       : received byte
//   dValid     : dOut valid, single-cycle pulse
//   frameStart : qualifies dValid, byte is frame byte 0
//   sync       : receiver is locked
//   syncErr    : pulse, full sync seen while locked but off a frame boundary
// Handshake: there is no back-pressure. Input side: a sample is consumed in
// every cycle traceValid is high. Output side: dOut/frameStart are meaningful
// only in the cycle dValid is high; the consumer must take the byte then.
module tpiu_frame_rx
  import tpiu_pkg::*;
#(
  parameter int MAX_WIDTH   = 4,
  parameter int FRAME_BYTES = TPIU_FRAME_BYTES,
  parameter int DELAY       = 4
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic [1:0]           width,
  input  logic [MAX_WIDTH-1:0] traceDin,
  input  logic                 traceValid,
  output logic [7:0]           dOut,
  output logic                 dValid,
  output logic                 frameStart,
  output logic                 sync,
  output logic                 syncErr
);

  localparam int FW = $clog2(FRAME_BYTES);
  localparam int CW = $clog2(DELAY + 1);

  rx_state_e     state_q, state_d;
  logic [31:0]   win_q, win_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]    width_q;
  logic [7:0]    dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic          frame_start_q, frame_start_d;
  logic          sync_q, sync_d;
  logic          sync_err_q, sync_err_d;

  logic [3:0]    w;
  logic [7:0]    din8;
  logic [3:0]    bit_sum;
  logic          match;
  logic          byte_done;
  logic          width_chg;
  logic          push;
  logic          flush;
  logic [7:0]    dl_dout;
  logic          dl_valid;
  logic [CW-1:0] dl_cnt;
  logic [FW-1:0] align_chk;

  tpiu_byte_delay #(.DELAY(DELAY), .CW(CW)) u_delay (
    .clk        (clk),
    .nRst       (nRst),
    .push       (push),
    .flush      (flush),
    .din        (win_d[31:24]),
    .dout       (dl_dout),
    .dout_valid (dl_valid),
    .valid_cnt  (dl_cnt)
  );

  // Sample shift, sync match and byte completion.
  always_comb begin
    w    = width_bits(width, MAX_WIDTH);
    din8 = '0;
    din8[MAX_WIDTH-1:0] = traceDin;
    // Newest bits enter at the top, so the byte just completed sits in [31:24].
    case (w)
      4'd1:    win_d = {din8[0],   win_q[31:1]};
      4'd2:    win_d = {din8[1:0], win_q[31:2]};
      4'd4:    win_d = {din8[3:0], win_q[31:4]};
      default: win_d = {din8,      win_q[31:8]};
    endcase
    if (!traceValid) begin
      win_d = win_q;
    end
    match     = traceValid && (win_d == TPIU_FULL_SYNC);
    bit_sum   = {1'b0, bit_cnt_q} + w;
    byte_done = traceValid && bit_sum[3];
    width_chg = (width != width_q);
    // The dropped 7F completes the four sync bytes together with what is
    // still pending, so data bytes since the last alignment are
    // emitted + pending + 1 - DELAY; a clean sync leaves a whole frame.
    align_chk = frame_cnt_q + FW'(dl_cnt) + FW'(1) - FW'(DELAY);
  end

  // Lock FSM and output byte selection.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    dout_d        = dout_q;
    dvalid_d      = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    case (state_q)
      RX_UNLOCKED: begin
        if (match) begin
          state_d     = RX_LOCKED;
          bit_cnt_d   = '0;
          frame_cnt_d = '0;
          flush       = 1'b1;
        end
      end
      RX_LOCKED: begin
        if (width_chg) begin
          state_d     = RX_UNLOCKED;
          bit_cnt_d   = '0;
          frame_cnt_d = '0;
          flush       = 1'b1;
        end else if (traceValid) begin
          bit_cnt_d = bit_sum[2:0];
          if (byte_done && match) begin
            // Sync wins over the byte it completes; pending bytes are dropped.
            flush       = 1'b1;
            bit_cnt_d   = '0;
            frame_cnt_d = '0;
            sync_err_d  = (align_chk != '0);
          end else if (byte_done) begin
            push = 1'b1;
            if (dl_valid) begin
              dout_d        = dl_dout;
              dvalid_d      = 1'b1;
              frame_start_d = (frame_cnt_q == '0);
              frame_cnt_d   = frame_cnt_q + FW'(1);
            end
          end
        end
      end
      default: state_d = RX_UNLOCKED;
    endcase
    sync_d = (state_d == RX_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q       <= RX_UNLOCKED;
      win_q         <= '0;
      bit_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      width_q       <= '0;
      dout_q        <= '0;
      dvalid_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_q        <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      width_q       <= width;
      dout_q        <= dout_d;
      dvalid_q      <= dvalid_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign dOut       = dout_q;
  assign dValid     = dvalid_q;
  assign frameStart = frame_start_q;
  assign sync       = sync_q;
  assign syncErr    = sync_err_q;

endmodule

// File: tb/tb_tpiu_frame_rx.sv
// tb_tpiu_frame_rx
//   Directed bench for tpiu_frame_rx (built with 8 port pins so every width
//   code is reachable). Output bytes are checked by a negedge scoreboard
//   against exp_q entries {frameStart, dOut}; syncErr pulses are counted.
module tb_tpiu_frame_rx;

  logic       clk = 1'b0;
  logic       nrst;
  logic [1:0] width;
  logic [7:0] trace_din;
  logic       trace_valid;
  logic [7:0] d_out;
  logic       d_valid;
  logic       frame_start;
  logic       sync;
  logic       sync_err;

  int checks   = 0;
  int errors   = 0;
  int serr_cnt = 0;
  int serr_base;

  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  typedef struct {
    logic [1:0] width;
    int         n_data;
    int         exp_err;
  } align_vec_t;

  align_vec_t vecs[7];
  logic [1:0] s1_widths[3];
  logic [7:0] s1_data[5];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tpiu_frame_rx #(
    .MAX_WIDTH   (8),
    .FRAME_BYTES (16),
    .DELAY       (4)
  ) dut (
    .clk        (clk),
    .nRst       (nrst),
    .width      (width),
    .traceDin   (trace_din),
    .traceValid (trace_valid),
    .dOut       (d_out),
    .dValid     (d_valid),
    .frameStart (frame_start),
    .sync       (sync),
    .syncErr    (sync_err)
  );

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (nrst) begin
      if (sync_err) serr_cnt++;
      if (d_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got dOut=%h frameStart=%b, required no output", d_out, frame_start);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({frame_start, d_out} !== mon_exp) begin
            errors++;
            $display("FAIL byte_stream: got frameStart=%b dOut=%h, required frameStart=%b dOut=%h",
                     frame_start, d_out, mon_exp[8], mon_exp[7:0]);
          end
        end
      end
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int bits_of(input logic [1:0] code);
    case (code)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trace_valid = 1'b0;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic send_sample(input logic [7:0] s);
    trace_din   = s;
    trace_valid = 1'b1;
    @(posedge clk);
    #1;
    trace_valid = 1'b0;
  endtask

  // Splits a byte LSB first into W-bit samples; pins above W carry junk.
  task automatic send_byte(input logic [7:0] b);
    int         w;
    logic [7:0] mask;
    logic [7:0] chunk;
    logic [7:0] junk;
    w    = bits_of(width);
    mask = 8'hFF >> (8 - w);
    for (int i = 0; i < 8 / w; i++) begin
      chunk = (b >> (i * w)) & mask;
      junk  = 8'($urandom_range(0, 255)) & ~mask;
      send_sample(chunk | junk);
    end
  endtask

  task automatic send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h7F);
  endtask

  task automatic start_at_width(input logic [1:0] code);
    do_reset();
    width = code;
    idle(1);
  endtask

  task automatic finish_scenario(input string name);
    idle(3);
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    nrst        = 1'b0;
    width       = 2'd2;
    trace_din   = '0;
    trace_valid = 1'b0;

    s1_widths = '{2'd2, 2'd0, 2'd3};
    s1_data   = '{8'h42, 8'h71, 8'h19, 8'h69, 8'h12};

    // width, data bytes between two syncs, expected syncErr pulses
    vecs[0] = '{2'd2, 16, 0};
    vecs[1] = '{2'd1,  5, 1};
    vecs[2] = '{2'd0,  3, 1};
    vecs[3] = '{2'd3, 16, 0};
    vecs[4] = '{2'd2,  0, 0};
    vecs[5] = '{2'd3, 17, 1};
    vecs[6] = '{2'd2, 32, 0};

    idle(3);
    check("reset_sync",       sync,        0);
    check("reset_dvalid",     d_valid,     0);
    check("reset_dout",       d_out,       0);
    check("reset_framestart", frame_start, 0);
    check("reset_syncerr",    sync_err,    0);
    nrst = 1'b1;

    // Lock after a preamble, then five bytes: only the first leaves the line.
    for (int k = 0; k < 3; k++) begin
      start_at_width(s1_widths[k]);
      serr_base = serr_cnt;
      send_byte(8'hFE);
      send_byte(8'h22);
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hFF);
      check("s1_sync_before_7f", sync, 0);
      send_byte(8'h7F);
      check("s1_sync_after_7f", sync, 1);
      exp_q.push_back({1'b1, 8'h42});
      for (int i = 0; i < 5; i++) send_byte(s1_data[i]);
      finish_scenario("s1_pending");
      check("s1_syncerr_count", serr_cnt - serr_base, 0);
      check("s1_still_locked", sync, 1);
    end

    // Table: lock, n data bytes, in-stream sync, five filler bytes.
    for (int v = 0; v < 7; v++) begin
      start_at_width(vecs[v].width);
      send_byte(8'hFE);
      send_byte(8'h22);
      send_sync();
      serr_base = serr_cnt;
      for (int i = 0; i < vecs[v].n_data; i++) begin
        // The last data byte is still in the line when the sync arrives.
        if (i < vecs[v].n_data - 1) exp_q.push_back({(i % 16) == 0, 8'(i)});
        send_byte(8'(i));
      end
      send_sync();
      check("vec_sync_after_resync", sync, 1);
      exp_q.push_back({1'b1, 8'hA0});
      for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
      finish_scenario("vec_pending");
      check("vec_syncerr_count", serr_cnt - serr_base, vecs[v].exp_err);
    end

    // Width 8: every sample completes a byte, output one cycle later.
    start_at_width(2'd3);
    send_sync();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    check("lat8_no_early", d_valid, 0);
    exp_q.push_back({1'b1, 8'h10});
    send_byte(8'h14);
    check("lat8_dvalid", d_valid, 1);
    check("lat8_dout", d_out, 8'h10);
    check("lat8_framestart", frame_start, 1);
    idle(1);
    check("lat8_pulse", d_valid, 0);
    exp_q.push_back({1'b0, 8'h11});
    send_byte(8'h15);
    check("lat8_second", d_valid, 1);
    finish_scenario("lat8_pending");

    // Width 1: output only after the eighth sample of a byte.
    start_at_width(2'd0);
    send_sync();
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
    exp_q.push_back({1'b1, 8'h20});
    for (int b = 0; b < 8; b++) begin
      send_sample({7'd0, (b == 2)});
      check("lat1_bit", d_valid, (b == 7) ? 1 : 0);
    end
    finish_scenario("lat1_pending");

    // Width change while locked drops lock; relock at the new width.
    start_at_width(2'd2);
    send_sync();
    exp_q.push_back({1'b1, 8'h42});
    for (int i = 0; i < 5; i++) send_byte(s1_data[i]);
    idle(2);
    width = 2'd1;
    idle(1);
    check("wchg_sync_drop", sync, 0);
    check("wchg_no_dvalid", d_valid, 0);
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
    check("wchg_stay_unlocked", sync, 0);
    send_sync();
    check("wchg_relock", sync, 1);
    exp_q.push_back({1'b1, 8'hB0});
    for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i));
    finish_scenario("wchg_pending");

    // Reset mid-byte while locked discards everything.
    start_at_width(2'd2);
    send_sync();
    exp_q.push_back({1'b1, 8'h42});
    for (int i = 0; i < 5; i++) send_byte(s1_data[i]);
    idle(2);
    send_sample(8'h03);
    do_reset();
    check("rst_sync",       sync,        0);
    check("rst_dvalid",     d_valid,     0);
    check("rst_dout",       d_out,       0);
    check("rst_framestart", frame_start, 0);
    check("rst_syncerr",    sync_err,    0);
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
    check("rst_no_lock", sync, 0);
    send_sync();
    check("rst_relock", sync, 1);
    exp_q.push_back({1'b1, 8'hC0});
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
    finish_scenario("rst_pending");

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
